// File: rtl/identificador_compuerta_pkg.sv
// Shared definitions for the gate identifier: FSM states, gate codes and the
// reference truth tables of the seven basic gates (bit index = {A,B}).
package identificador_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    APLICAR     = 3'd1,
    MUESTRA1    = 3'd2,
    MUESTRA2    = 3'd3,
    DECODIFICAR = 3'd4
  } estado_t;

  localparam logic [2:0] COD_DESCONOCIDO = 3'd0;
  localparam logic [2:0] COD_NOT_A       = 3'd1;
  localparam logic [2:0] COD_AND         = 3'd2;
  localparam logic [2:0] COD_OR          = 3'd3;
  localparam logic [2:0] COD_XOR         = 3'd4;
  localparam logic [2:0] COD_NAND        = 3'd5;
  localparam logic [2:0] COD_NOR         = 3'd6;
  localparam logic [2:0] COD_XNOR        = 3'd7;

  localparam logic [3:0] TT_NOT_A = 4'b0011;
  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic [3:0] TT_XOR   = 4'b0110;
  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_NOR   = 4'b0001;
  localparam logic [3:0] TT_XNOR  = 4'b1001;

  localparam logic [1:0] IDX_ULTIMO = 2'd3;

endpackage

// File: rtl/identificador_compuerta_if.sv
// Bundle between the gate identifier (master) and the gate/controller side (slave).
// Start/done contract: inicio is taken only on a clock edge where ocupado=0; each
// accepted start produces exactly one one-cycle valido pulse, after which tabla,
// codigo and inestable stay stable until the next accepted start.
interface identificador_compuerta_if;
  logic       inicio;
  logic       ocupado;
  logic       sal_A;
  logic       sal_B;
  logic       entrada_muestra;
  logic [3:0] tabla;
  logic [2:0] codigo;
  logic       valido;
  logic       inestable;

  modport master (
    input  inicio,
    input  entrada_muestra,
    output ocupado,
    output sal_A,
    output sal_B,
    output tabla,
    output codigo,
    output valido,
    output inestable
  );

  modport slave (
    output inicio,
    output entrada_muestra,
    input  ocupado,
    input  sal_A,
    input  sal_B,
    input  tabla,
    input  codigo,
    input  valido,
    input  inestable
  );
endinterface

// File: rtl/identificador_compuerta_decodificador_tabla.sv
// Combinational truth-table decoder: maps a captured 4-bit table to a gate code,
// returning COD_DESCONOCIDO for any pattern that is not one of the seven gates.
module decodificador_tabla
  import identificador_pkg::*;
(
  input  logic [3:0] i_tabla,
  output logic [2:0] o_codigo
);

  always_comb begin
    o_codigo = COD_DESCONOCIDO;
    case (i_tabla)
      TT_NOT_A: o_codigo = COD_NOT_A;
      TT_AND:   o_codigo = COD_AND;
      TT_OR:    o_codigo = COD_OR;
      TT_XOR:   o_codigo = COD_XOR;
      TT_NAND:  o_codigo = COD_NAND;
      TT_NOR:   o_codigo = COD_NOR;
      TT_XNOR:  o_codigo = COD_XNOR;
      default:  o_codigo = COD_DESCONOCIDO;
    endcase
  end

endmodule

// File: rtl/identificador_compuerta.sv
// Sequential gate identifier: walks AB through 00..11, double-samples the gate
// output for each combination and decodes the resulting truth table.
module identificador_compuerta
  import identificador_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  identificador_compuerta_if.master     bus,
  output estado_t                       o_estado
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_CARGA = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_UNO   = CW'(1);

  estado_t       r_estado;
  estado_t       w_estado_sig;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_s1;
  logic [3:0]    r_tabla;
  logic [2:0]    r_codigo;
  logic          r_valido;
  logic          r_inestable;
  logic [2:0]    w_codigo_dec;
  logic          w_conducir;

  decodificador_tabla u_decodificador (
    .i_tabla  (r_tabla),
    .o_codigo (w_codigo_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      IDLE:        if (bus.inicio) w_estado_sig = APLICAR;
      APLICAR:     if (r_cnt == CNT_UNO) w_estado_sig = MUESTRA1;
      MUESTRA1:    w_estado_sig = MUESTRA2;
      MUESTRA2:    w_estado_sig = (r_idx == IDX_ULTIMO) ? DECODIFICAR : APLICAR;
      DECODIFICAR: w_estado_sig = IDLE;
      default:     w_estado_sig = IDLE;
    endcase
  end

  // The counter is reloaded on every entry to APLICAR, so it only counts down there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_s1        <= 1'b0;
      r_tabla     <= '0;
      r_codigo    <= '0;
      r_valido    <= 1'b0;
      r_inestable <= 1'b0;
    end else begin
      r_valido <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (bus.inicio) begin
            r_idx       <= '0;
            r_cnt       <= CNT_CARGA;
            r_tabla     <= '0;
            r_codigo    <= '0;
            r_inestable <= 1'b0;
          end
        end
        APLICAR: begin
          if (r_cnt != CNT_UNO) r_cnt <= r_cnt - CNT_UNO;
        end
        MUESTRA1: begin
          r_s1           <= bus.entrada_muestra;
          r_tabla[r_idx] <= bus.entrada_muestra;
        end
        MUESTRA2: begin
          if (bus.entrada_muestra != r_s1) r_inestable <= 1'b1;
          if (r_idx != IDX_ULTIMO) begin
            r_idx <= r_idx + 2'd1;
            r_cnt <= CNT_CARGA;
          end
        end
        DECODIFICAR: begin
          r_codigo <= r_inestable ? COD_DESCONOCIDO : w_codigo_dec;
          r_valido <= 1'b1;
        end
        default: begin
          r_valido <= 1'b0;
        end
      endcase
    end
  end

  // Gate inputs are driven only while a combination is being applied or sampled.
  assign w_conducir = (r_estado == APLICAR) || (r_estado == MUESTRA1) ||
                      (r_estado == MUESTRA2);

  assign bus.ocupado   = (r_estado != IDLE);
  assign bus.sal_A     = w_conducir & r_idx[1];
  assign bus.sal_B     = w_conducir & r_idx[0];
  assign bus.tabla     = r_tabla;
  assign bus.codigo    = r_codigo;
  assign bus.valido    = r_valido;
  assign bus.inestable = r_inestable;
  assign o_estado      = r_estado;

endmodule

// File: tb/tb_identificador_compuerta.sv
// Bench for identificador_compuerta: a behavioural gate model closes the loop,
// per-cycle expectations flow through exp_q, results are checked per run.
module tb_identificador_compuerta;
  import identificador_pkg::*;

  localparam int S   = 2;
  localparam int L   = 4 * (S + 2);
  localparam int NCY = L + 4;

  typedef struct {
    int         mode;
    logic [3:0] exp_tabla;
    logic [2:0] exp_codigo;
  } vec_t;

  logic       clk;
  logic       rst_n;
  estado_t    dbg_estado;
  int         mode;
  logic [3:0] rand_tab;
  logic       ovr_en;
  logic       ovr_val;
  logic [3:0] dec_t;
  logic [2:0] dec_c;
  int         total;
  int         bad;
  logic [3:0] exp_q[$];

  identificador_compuerta_if u_if ();

  identificador_compuerta #(.SETTLE_CYCLES(S)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (u_if),
    .o_estado (dbg_estado)
  );

  decodificador_tabla u_dec (
    .i_tabla  (dec_t),
    .o_codigo (dec_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  function automatic logic gate_out(int m, logic a, logic b, logic [3:0] rt);
    case (m)
      0:       return 1'b0;
      1:       return !a;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      5:       return !(a & b);
      6:       return !(a | b);
      7:       return !(a ^ b);
      8:       return 1'b1;
      default: return rt[{a, b}];
    endcase
  endfunction

  function automatic logic [3:0] model_tabla(int m, logic [3:0] rt);
    logic [3:0] t;
    t = '0;
    for (int i = 0; i < 4; i++) t[i] = gate_out(m, i[1], i[0], rt);
    return t;
  endfunction

  function automatic logic [2:0] model_codigo(logic [3:0] t);
    for (int g = 1; g <= 7; g++)
      if (model_tabla(g, 4'b0000) == t) return 3'(g);
    return 3'd0;
  endfunction

  always_comb begin
    u_if.entrada_muestra = ovr_en ? ovr_val : gate_out(mode, u_if.sal_A, u_if.sal_B, rand_tab);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs_all();
    return {u_if.ocupado, u_if.sal_A, u_if.sal_B, u_if.valido, u_if.inestable,
            u_if.codigo};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_check(input string name, input int m, input logic [3:0] rt,
                           input int glitch_k, input int extra_k,
                           input logic [3:0] e_tabla, input logic [2:0] e_cod,
                           input logic e_inest);
    logic [3:0] e;
    int         c;
    mode     = m;
    rand_tab = rt;
    for (int k = 0; k < NCY; k++) begin
      c = (k < L) ? k / (S + 2) : 0;
      exp_q.push_back({(k <= L) ? 1'b1 : 1'b0, c[1:0], (k == L + 1) ? 1'b1 : 1'b0});
    end
    @(negedge clk) u_if.inicio = 1'b1;
    @(posedge clk);
    #1 u_if.inicio = 1'b0;
    for (int k = 0; k < NCY; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      e = exp_q.pop_front();
      chk($sformatf("%s cyc%0d", name, k),
          {u_if.ocupado, u_if.sal_A, u_if.sal_B, u_if.valido}, e);
      if (k == L + 1) begin
        chk({name, " tabla"}, u_if.tabla, e_tabla);
        chk({name, " codigo"}, u_if.codigo, e_cod);
        chk({name, " inestable"}, u_if.inestable, e_inest);
      end
      if (k == NCY - 1) chk({name, " hold"}, {u_if.tabla, u_if.codigo}, {e_tabla, e_cod});
      if (k == extra_k) u_if.inicio = 1'b1;
      if (k == extra_k + 1) u_if.inicio = 1'b0;
      if (k == glitch_k) begin
        c = k / (S + 2);
        ovr_val = !gate_out(m, c[1], c[0], rt);
        ovr_en  = 1'b1;
      end
      if (k == glitch_k + 1) ovr_en = 1'b0;
    end
    u_if.inicio = 1'b0;
    ovr_en      = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[9];

  initial begin
    int         vcnt;
    int         got_pos[$];
    int         exp_pos[$];
    int         waited;
    int         m;
    int         gk;
    logic [3:0] rt;
    logic [3:0] et;
    logic       gl;

    vecs[0] = '{2, 4'b1000, 3'd2};
    vecs[1] = '{1, 4'b0011, 3'd1};
    vecs[2] = '{3, 4'b1110, 3'd3};
    vecs[3] = '{4, 4'b0110, 3'd4};
    vecs[4] = '{5, 4'b0111, 3'd5};
    vecs[5] = '{6, 4'b0001, 3'd6};
    vecs[6] = '{7, 4'b1001, 3'd7};
    vecs[7] = '{0, 4'b0000, 3'd0};
    vecs[8] = '{8, 4'b1111, 3'd0};

    total = 0;
    bad = 0;
    rst_n = 1'b0;
    u_if.inicio = 1'b0;
    mode = 2;
    rand_tab = '0;
    ovr_en = 1'b0;
    ovr_val = 1'b0;
    dec_t = '0;

    #22;
    chk("reset outs", outs_all(), 8'h00);
    chk("reset tabla", u_if.tabla, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 chk($sformatf("idle cyc%0d", k), outs_all(), 8'h00);
    end
    chk("idle state", dbg_estado, IDLE);

    for (int i = 0; i < 16; i++) begin
      dec_t = 4'(i);
      #1 chk($sformatf("dec %0d", i), dec_c, model_codigo(4'(i)));
    end

    for (int i = 0; i < 9; i++)
      run_check($sformatf("vec%0d", i), vecs[i].mode, 4'h0, -10, -10,
                vecs[i].exp_tabla, vecs[i].exp_codigo, 1'b0);

    // Toggle the XOR output between the two samples of combination 01.
    run_check("glitch", 4, 4'h0, (S + 2) + S + 1, -10, 4'b0110, 3'd0, 1'b1);

    run_check("midstart", 2, 4'h0, -10, 5, 4'b1000, 3'd2, 1'b0);

    // inicio held high: a new run is accepted in the cycle valido is shown.
    mode = 3;
    exp_pos.delete();
    got_pos.delete();
    for (int n = 0; n * (L + 2) + L + 1 < 40; n++) exp_pos.push_back(n * (L + 2) + L + 1);
    @(negedge clk) u_if.inicio = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 if (u_if.valido) got_pos.push_back(k);
    end
    chk("hold count", got_pos.size(), exp_pos.size());
    for (int i = 0; i < exp_pos.size(); i++)
      chk($sformatf("hold pos%0d", i), (i < got_pos.size()) ? got_pos[i] : -1, exp_pos[i]);
    @(negedge clk) u_if.inicio = 1'b0;
    waited = 0;
    while (!u_if.valido && waited < 3 * L) begin
      @(posedge clk);
      #1 waited++;
    end
    chk("hold tail valido", u_if.valido, 1'b1);
    chk("hold tail codigo", u_if.codigo, 3'd3);
    repeat (2) @(posedge clk);

    // Reset in cycle 6 of a run.
    mode = 2;
    @(negedge clk) u_if.inicio = 1'b1;
    @(posedge clk);
    #1 u_if.inicio = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("pre-reset busy", u_if.ocupado, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async reset outs", outs_all(), 8'h00);
    chk("async reset tabla", u_if.tabla, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < L + 4; k++) begin
      @(posedge clk);
      #1 if (u_if.valido || u_if.ocupado) vcnt++;
    end
    chk("post-reset quiet", vcnt, 0);
    run_check("after reset", 2, 4'h0, -10, -10, 4'b1000, 3'd2, 1'b0);

    // Randomized runs against the model, some with a sample disagreement injected.
    for (int r = 0; r < 24; r++) begin
      m  = $urandom_range(0, 9);
      rt = 4'($urandom_range(0, 15));
      gl = ($urandom_range(0, 3) == 0);
      gk = gl ? int'($urandom_range(0, 3)) * (S + 2) + S + 1 : -10;
      et = model_tabla(m, rt);
      run_check($sformatf("rnd%0d m%0d", r, m), m, rt, gk, -10, et,
                gl ? 3'd0 : model_codigo(et), gl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
